// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle logic/arith/shift ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), all launched by a start handshake.
module multicycle_alu #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [5:0]       fun_sel_i,
   input  logic             wf_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] alu_out_o,
   output logic [WIDTH-1:0] alu_out_hi_o,
   output logic [3:0]       flags_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(WIDTH);

   localparam int FZ = 3;
   localparam int FC = 2;
   localparam int FN = 1;
   localparam int FO = 0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] opb_q;
   logic             is_div_q;
   logic             wf_q;
   logic [WIDTH-1:0] alu_out_q;
   logic [WIDTH-1:0] alu_out_hi_q;
   logic [3:0]       flags_q;
   logic             busy_q;
   logic             done_q;

   // single-cycle datapath
   logic             full_s;
   logic [3:0]       op_s;
   logic [CW-1:0]    msb_idx_s;
   logic [WIDTH-1:0] aa_s;
   logic [WIDTH-1:0] bb_s;
   logic             a_msb_s;
   logic             b_msb_s;
   logic             r_msb_s;
   logic             cin_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   dif_s;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH-1:0] sc_out_d;
   logic [3:0]       sc_flags_d;

   // iterative datapath
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_sh_s;
   logic [WIDTH:0]   div_df_s;
   logic [WIDTH-1:0] it_hi_d;
   logic [WIDTH-1:0] it_lo_d;
   logic [3:0]       mc_flags_d;

   assign alu_out_o    = alu_out_q;
   assign alu_out_hi_o = alu_out_hi_q;
   assign flags_o      = flags_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

   // Half-width ops run on zero-extended low halves; flag bit positions follow msb_idx_s.
   always_comb begin
      full_s    = fun_sel_i[4];
      op_s      = fun_sel_i[3:0];
      msb_idx_s = full_s ? CW'(WIDTH - 1) : CW'(H - 1);
      aa_s      = full_s ? a_i : {{(WIDTH - H){1'b0}}, a_i[H-1:0]};
      bb_s      = full_s ? b_i : {{(WIDTH - H){1'b0}}, b_i[H-1:0]};
      a_msb_s   = aa_s[msb_idx_s];
      b_msb_s   = bb_s[msb_idx_s];
      cin_s     = (op_s == 4'h5) ? flags_q[FC] : 1'b0;
      sum_s     = {1'b0, aa_s} + {1'b0, bb_s} + {{WIDTH{1'b0}}, cin_s};
      dif_s     = {1'b0, aa_s} - {1'b0, bb_s};
      res_s     = aa_s;
      sc_flags_d = flags_q;
      case (op_s)
         4'h0: res_s = aa_s;
         4'h1: res_s = bb_s;
         4'h2: res_s = ~aa_s;
         4'h3: res_s = ~bb_s;
         4'h4, 4'h5: begin
            res_s          = sum_s[WIDTH-1:0];
            sc_flags_d[FC] = full_s ? sum_s[WIDTH] : sum_s[H];
         end
         4'h6: begin
            res_s          = dif_s[WIDTH-1:0];
            sc_flags_d[FC] = full_s ? dif_s[WIDTH] : dif_s[H];
         end
         4'h7: res_s = aa_s & bb_s;
         4'h8: res_s = aa_s | bb_s;
         4'h9: res_s = aa_s ^ bb_s;
         4'hA: res_s = ~(aa_s & bb_s);
         4'hB: begin
            res_s          = aa_s << 1;
            sc_flags_d[FC] = a_msb_s;
         end
         4'hC: begin
            res_s          = aa_s >> 1;
            sc_flags_d[FC] = aa_s[0];
         end
         4'hD: begin
            res_s          = (aa_s >> 1) | (WIDTH'(a_msb_s) << msb_idx_s);
            sc_flags_d[FC] = aa_s[0];
         end
         4'hE: begin
            res_s          = (aa_s << 1) | WIDTH'(a_msb_s);
            sc_flags_d[FC] = a_msb_s;
         end
         4'hF: begin
            res_s          = (aa_s >> 1) | (WIDTH'(aa_s[0]) << msb_idx_s);
            sc_flags_d[FC] = aa_s[0];
         end
         default: res_s = aa_s;
      endcase
      r_msb_s  = res_s[msb_idx_s];
      sc_out_d = full_s ? res_s : {{(WIDTH - H){res_s[H-1]}}, res_s[H-1:0]};
      sc_flags_d[FZ] = full_s ? (res_s == {WIDTH{1'b0}}) : (res_s[H-1:0] == {H{1'b0}});
      if (op_s == 4'hD) begin
         sc_flags_d[FN] = flags_q[FN];
      end else begin
         sc_flags_d[FN] = sc_out_d[WIDTH-1];
      end
      if (op_s == 4'h4 || op_s == 4'h5) begin
         sc_flags_d[FO] = (a_msb_s == b_msb_s) && (r_msb_s != a_msb_s);
      end else if (op_s == 4'h6) begin
         sc_flags_d[FO] = (a_msb_s != b_msb_s) && (r_msb_s != a_msb_s);
      end else begin
         sc_flags_d[FO] = flags_q[FO];
      end
   end

   // One multiply or divide step; hi_q is the partial product / remainder, lo_q the multiplier / quotient.
   always_comb begin
      mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
      div_sh_s  = {hi_q, lo_q[WIDTH-1]};
      div_df_s  = div_sh_s - {1'b0, opb_q};
      mc_flags_d = flags_q;
      if (is_div_q) begin
         if (!div_df_s[WIDTH]) begin
            it_hi_d = div_df_s[WIDTH-1:0];
            it_lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            it_hi_d = div_sh_s[WIDTH-1:0];
            it_lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
         mc_flags_d[FZ] = (it_lo_d == {WIDTH{1'b0}});
         mc_flags_d[FC] = 1'b0;
         mc_flags_d[FO] = 1'b0;
      end else begin
         it_hi_d = mul_sum_s[WIDTH:1];
         it_lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
         mc_flags_d[FZ] = ({it_hi_d, it_lo_d} == {(2 * WIDTH){1'b0}});
         mc_flags_d[FC] = (it_hi_d != {WIDTH{1'b0}});
      end
   end

   // Control FSM and all architectural registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= {CW{1'b0}};
         hi_q         <= {WIDTH{1'b0}};
         lo_q         <= {WIDTH{1'b0}};
         opb_q        <= {WIDTH{1'b0}};
         is_div_q     <= 1'b0;
         wf_q         <= 1'b0;
         alu_out_q    <= {WIDTH{1'b0}};
         alu_out_hi_q <= {WIDTH{1'b0}};
         flags_q      <= 4'b0000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  if (!fun_sel_i[5]) begin
                     alu_out_q    <= sc_out_d;
                     alu_out_hi_q <= {WIDTH{1'b0}};
                     if (wf_i) begin
                        flags_q <= sc_flags_d;
                     end
                     done_q <= 1'b1;
                  end else if (fun_sel_i[3:0] == 4'h0 ||
                               (fun_sel_i[3:0] == 4'h1 && b_i != {WIDTH{1'b0}})) begin
                     state_q  <= ST_RUN;
                     busy_q   <= 1'b1;
                     cnt_q    <= {CW{1'b0}};
                     hi_q     <= {WIDTH{1'b0}};
                     lo_q     <= a_i;
                     opb_q    <= b_i;
                     is_div_q <= fun_sel_i[0];
                     wf_q     <= wf_i;
                  end else if (fun_sel_i[3:0] == 4'h1) begin
                     // divide by zero: saturated quotient, dividend kept as remainder
                     alu_out_q    <= {WIDTH{1'b1}};
                     alu_out_hi_q <= a_i;
                     if (wf_i) begin
                        flags_q[FZ] <= 1'b0;
                        flags_q[FC] <= 1'b0;
                        flags_q[FO] <= 1'b1;
                     end
                     done_q <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               hi_q <= it_hi_d;
               lo_q <= it_lo_d;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q      <= ST_IDLE;
                  busy_q       <= 1'b0;
                  done_q       <= 1'b1;
                  cnt_q        <= {CW{1'b0}};
                  alu_out_q    <= it_lo_d;
                  alu_out_hi_q <= it_hi_d;
                  if (wf_q) begin
                     flags_q <= mc_flags_d;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
